// File: rtl/oci_trace_pkg.sv
// Shared types and helpers for the OCI debug-trace capture buffer.
package oci_trace_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        ENDED = 2'd2
    } trace_state_e;

    localparam int OVW_DROP   = 0;
    localparam int OVW_OLDEST = 1;

    // One extra bit so the occupancy counter can represent a completely full buffer.
    function automatic int trace_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/oci_trace_ram.sv
// Trace storage: one synchronous write port and one asynchronous read port.
// Write data is visible on the read port from the cycle after the write.
module oci_trace_ram #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/oci_trace_capture.sv
// Trace capture buffer: 1-cycle write-to-read latency, combinational head read.
// Producer is stalled (or the oldest word overwritten) when full; flush blocks writes.
module oci_trace_capture
    import oci_trace_pkg::*;
#(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = trace_cnt_w(DEPTH),
    parameter int OVERWRITE = OVW_DROP,
    parameter int DROP_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic [DROP_W-1:0] lost_count,
    input  logic              test_ending,
    output logic              test_has_ended
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    trace_state_e      state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] buffer_q, buffer_d;
    logic [DROP_W-1:0] lost_q, lost_d;

    logic run, full, empty, wr, pop, ovw, drop;

    // in_ready depends only on registered state so the producer never sees rd_ready.
    always_comb begin
        run      = (state_q == RUN);
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        in_ready = run && ((OVERWRITE == OVW_OLDEST) || !full);
        wr       = in_valid && in_ready;
        pop      = rd_ready && !empty;
        ovw      = wr && full && !pop;
        drop     = run && in_valid && !in_ready;

        wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = (pop || ovw) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        buffer_d = wr ? in_data : buffer_q;

        count_d = count_q;
        if (wr && !pop && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        lost_d = lost_q;
        if ((drop || ovw) && (lost_q != '1)) begin
            lost_d = lost_q + DROP_W'(1);
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (test_ending) state_d = FLUSH;
            FLUSH:   if (empty)       state_d = ENDED;
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            buffer_q <= '0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            buffer_q <= buffer_d;
            lost_q   <= lost_d;
        end
    end

    oci_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign rd_valid       = !empty;
    assign dct_buffer     = buffer_q;
    assign dct_count      = count_q;
    assign lost_count     = lost_q;
    assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_oci_trace_capture.sv
// Directed bench: drop-mode, overwrite-mode and narrow lost-counter instances share stimulus.
module tb_oci_trace_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, in_valid, rd_ready, test_ending;
    logic [29:0] in_data;

    logic        in_ready   [3];
    logic        rd_valid   [3];
    logic        has_ended  [3];
    logic [29:0] rd_data    [3];
    logic [29:0] dct_buffer [3];
    logic [2:0]  dct_count  [3];
    logic [7:0]  lost0, lost1;
    logic [1:0]  lost2;

    int errors = 0;
    int checks = 0;

    oci_trace_capture #(.DATA_W(30), .DEPTH(4), .OVERWRITE(0), .DROP_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
        .rd_ready(rd_ready), .dct_buffer(dct_buffer[0]), .dct_count(dct_count[0]),
        .lost_count(lost0), .test_ending(test_ending), .test_has_ended(has_ended[0]));

    oci_trace_capture #(.DATA_W(30), .DEPTH(4), .OVERWRITE(1), .DROP_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
        .rd_ready(rd_ready), .dct_buffer(dct_buffer[1]), .dct_count(dct_count[1]),
        .lost_count(lost1), .test_ending(test_ending), .test_has_ended(has_ended[1]));

    oci_trace_capture #(.DATA_W(30), .DEPTH(4), .OVERWRITE(0), .DROP_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
        .rd_ready(rd_ready), .dct_buffer(dct_buffer[2]), .dct_count(dct_count[2]),
        .lost_count(lost2), .test_ending(test_ending), .test_has_ended(has_ended[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; rd_ready = 1'b0; test_ending = 1'b0; in_data = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%0b want=1", i, in_ready[i]); end
            checks++; if (rd_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid[%0d] got=%0b want=0", i, rd_valid[i]); end
            checks++; if (has_ended[i] !== 1'b0) begin errors++; $display("FAIL reset_has_ended[%0d] got=%0b want=0", i, has_ended[i]); end
            checks++; if (dct_count[i] !== 3'd0) begin errors++; $display("FAIL reset_count[%0d] got=%0d want=0", i, dct_count[i]); end
            checks++; if (dct_buffer[i] !== 30'h0) begin errors++; $display("FAIL reset_buffer[%0d] got=%0h want=0", i, dct_buffer[i]); end
        end
        checks++; if (lost0 !== 8'd0) begin errors++; $display("FAIL reset_lost0 got=%0d want=0", lost0); end
        checks++; if (lost1 !== 8'd0) begin errors++; $display("FAIL reset_lost1 got=%0d want=0", lost1); end
        checks++; if (lost2 !== 2'd0) begin errors++; $display("FAIL reset_lost2 got=%0d want=0", lost2); end
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1; in_data = 30'h1;
        step();
        checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_rd_valid_rise got=%0b want=1", rd_valid[0]); end
        in_data = 30'h2;
        step();
        in_valid = 1'b0;
        checks++; if (dct_count[0] !== 3'd2) begin errors++; $display("FAIL basic_count got=%0d want=2", dct_count[0]); end
        checks++; if (dct_buffer[0] !== 30'h2) begin errors++; $display("FAIL basic_buffer got=%0h want=2", dct_buffer[0]); end
        checks++; if (rd_data[0] !== 30'h1) begin errors++; $display("FAIL basic_head got=%0h want=1", rd_data[0]); end
        rd_ready = 1'b1;
        step();
        checks++; if (rd_data[0] !== 30'h2) begin errors++; $display("FAIL basic_pop2 got=%0h want=2", rd_data[0]); end
        checks++; if (dct_count[0] !== 3'd1) begin errors++; $display("FAIL basic_count1 got=%0d want=1", dct_count[0]); end
        step();
        rd_ready = 1'b0;
        checks++; if (dct_count[0] !== 3'd0) begin errors++; $display("FAIL basic_count0 got=%0d want=0", dct_count[0]); end
        checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_empty got=%0b want=0", rd_valid[0]); end
    endtask

    task automatic test_full_drop();
        logic [29:0] exp;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 30'(32'h10 + i);
            step();
            if (i == 3) begin
                checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL drop_in_ready_full got=%0b want=0", in_ready[0]); end
            end
        end
        in_valid = 1'b0;
        checks++; if (lost0 !== 8'd2) begin errors++; $display("FAIL drop_lost got=%0d want=2", lost0); end
        checks++; if (dct_count[0] !== 3'd4) begin errors++; $display("FAIL drop_count got=%0d want=4", dct_count[0]); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 30'(32'h10 + i);
            checks++; if (rd_data[0] !== exp) begin errors++; $display("FAIL drop_read[%0d] got=%0h want=%0h", i, rd_data[0], exp); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL drop_drained got=%0b want=0", rd_valid[0]); end
    endtask

    task automatic test_overwrite();
        logic [29:0] exp;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 30'(32'h20 + i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (dct_count[1] !== 3'd4) begin errors++; $display("FAIL ovw_count got=%0d want=4", dct_count[1]); end
        checks++; if (lost1 !== 8'd2) begin errors++; $display("FAIL ovw_lost got=%0d want=2", lost1); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 30'(32'h22 + i);
            checks++; if (rd_data[1] !== exp) begin errors++; $display("FAIL ovw_read[%0d] got=%0h want=%0h", i, rd_data[1], exp); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid[1] !== 1'b0) begin errors++; $display("FAIL ovw_drained got=%0b want=0", rd_valid[1]); end
    endtask

    task automatic test_full_wr_pop();
        logic [29:0] exp;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 30'(32'h30 + i);
            step();
        end
        in_data = 30'h34; rd_ready = 1'b1;
        checks++; if (rd_data[1] !== 30'h30) begin errors++; $display("FAIL wrpop_old_head got=%0h want=30", rd_data[1]); end
        step();
        in_valid = 1'b0; rd_ready = 1'b0;
        checks++; if (dct_count[1] !== 3'd4) begin errors++; $display("FAIL wrpop_count got=%0d want=4", dct_count[1]); end
        checks++; if (lost1 !== 8'd0) begin errors++; $display("FAIL wrpop_lost got=%0d want=0", lost1); end
        checks++; if (dct_count[0] !== 3'd3) begin errors++; $display("FAIL wrpop_drop_count got=%0d want=3", dct_count[0]); end
        checks++; if (lost0 !== 8'd1) begin errors++; $display("FAIL wrpop_drop_lost got=%0d want=1", lost0); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 30'(32'h31 + i);
            checks++; if (rd_data[1] !== exp) begin errors++; $display("FAIL wrpop_read[%0d] got=%0h want=%0h", i, rd_data[1], exp); end
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [29:0] exp;
        do_reset();
        in_valid = 1'b1; in_data = 30'h40;
        step();
        in_data = 30'h41;
        step();
        in_data = 30'h42; test_ending = 1'b1;
        step();
        test_ending = 1'b0; in_data = 30'h7f;
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b want=0", in_ready[0]); end
        checks++; if (dct_count[0] !== 3'd3) begin errors++; $display("FAIL flush_same_cycle_write got=%0d want=3", dct_count[0]); end
        step();
        checks++; if (dct_count[0] !== 3'd3) begin errors++; $display("FAIL flush_no_store got=%0d want=3", dct_count[0]); end
        checks++; if (lost0 !== 8'd0) begin errors++; $display("FAIL flush_lost got=%0d want=0", lost0); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 30'(32'h40 + i);
            checks++; if (rd_data[0] !== exp) begin errors++; $display("FAIL flush_read[%0d] got=%0h want=%0h", i, rd_data[0], exp); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (dct_count[0] !== 3'd0) begin errors++; $display("FAIL flush_count0 got=%0d want=0", dct_count[0]); end
        checks++; if (has_ended[0] !== 1'b0) begin errors++; $display("FAIL flush_ended_early got=%0b want=0", has_ended[0]); end
        step();
        checks++; if (has_ended[0] !== 1'b1) begin errors++; $display("FAIL flush_ended got=%0b want=1", has_ended[0]); end
        step();
        step();
        in_valid = 1'b0;
        checks++; if (has_ended[0] !== 1'b1) begin errors++; $display("FAIL flush_ended_sticky got=%0b want=1", has_ended[0]); end
        checks++; if (lost0 !== 8'd0) begin errors++; $display("FAIL flush_lost_end got=%0d want=0", lost0); end
        checks++; if (dct_buffer[0] !== 30'h42) begin errors++; $display("FAIL flush_buffer got=%0h want=42", dct_buffer[0]); end
    endtask

    task automatic test_flush_empty();
        do_reset();
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        checks++; if (has_ended[0] !== 1'b0) begin errors++; $display("FAIL empty_flush_1cyc got=%0b want=0", has_ended[0]); end
        step();
        checks++; if (has_ended[0] !== 1'b1) begin errors++; $display("FAIL empty_flush_2cyc got=%0b want=1", has_ended[0]); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        in_valid = 1'b1; in_data = 30'h50;
        step();
        in_data = 30'h51;
        step();
        in_valid = 1'b0; test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL midflush_blocked got=%0b want=0", in_ready[0]); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL midflush_in_ready got=%0b want=1", in_ready[0]); end
        checks++; if (dct_count[0] !== 3'd0) begin errors++; $display("FAIL midflush_count got=%0d want=0", dct_count[0]); end
        checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL midflush_rd_valid got=%0b want=0", rd_valid[0]); end
        checks++; if (has_ended[0] !== 1'b0) begin errors++; $display("FAIL midflush_ended got=%0b want=0", has_ended[0]); end
        checks++; if (dct_buffer[0] !== 30'h0) begin errors++; $display("FAIL midflush_buffer got=%0h want=0", dct_buffer[0]); end
        in_valid = 1'b1; in_data = 30'h52;
        step();
        in_valid = 1'b0;
        checks++; if (rd_data[0] !== 30'h52) begin errors++; $display("FAIL midflush_run_write got=%0h want=52", rd_data[0]); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 30'(32'h60 + i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (lost0 !== 8'd5) begin errors++; $display("FAIL sat_lost_wide got=%0d want=5", lost0); end
        checks++; if (lost2 !== 2'd3) begin errors++; $display("FAIL sat_lost_narrow got=%0d want=3", lost2); end
        checks++; if (dct_count[2] !== 3'd4) begin errors++; $display("FAIL sat_count got=%0d want=4", dct_count[2]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; rd_ready = 1'b0; test_ending = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_full_drop();
        test_overwrite();
        test_full_wr_pop();
        test_flush();
        test_flush_empty();
        test_reset_mid_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
